// File: rtl/idli_trace_m_pkg.sv
// Shared types for the idli trace capture block.
// IDLI_TRACE_TIMESTAMP_EN adds a capture-time field to each trace record.
package idli_pkg;

   typedef logic [15:0] idli_trace_seq_t;
   typedef logic [31:0] idli_trace_time_t;

   function automatic int unsigned idli_trace_beats(input int unsigned data_w,
                                                    input int unsigned slice_w);
      return data_w / slice_w;
   endfunction

   // The per-channel data words are parameter-sized, so the top prepends them to this record.
   typedef struct packed {
      idli_trace_seq_t  seq;
`ifdef IDLI_TRACE_TIMESTAMP_EN
      idli_trace_time_t stamp;
`endif
   } idli_trace_meta_t;

endpackage

// File: rtl/idli_trace_m_if.sv
// Drain-side valid/ready bus of the trace FIFO.
// IDLI_TRACE_TIMESTAMP_EN adds o_trc_time to the bus.
interface idli_trace_m_if
   import idli_pkg::*;
#(
   parameter int unsigned DATA_W   = 16,
   parameter int unsigned CHANNELS = 2
) ();

   logic                             o_trc_vld;
   logic                             i_trc_rdy;
   logic [CHANNELS-1:0][DATA_W-1:0]  o_trc_data;
   idli_trace_seq_t                  o_trc_seq;
`ifdef IDLI_TRACE_TIMESTAMP_EN
   idli_trace_time_t                 o_trc_time;

   modport master (output o_trc_vld, o_trc_data, o_trc_seq, o_trc_time, input i_trc_rdy);
   modport slave  (input o_trc_vld, o_trc_data, o_trc_seq, o_trc_time, output i_trc_rdy);
`else
   modport master (output o_trc_vld, o_trc_data, o_trc_seq, input i_trc_rdy);
   modport slave  (input o_trc_vld, o_trc_data, o_trc_seq, output i_trc_rdy);
`endif

endinterface

// File: rtl/idli_trace_m_fifo.sv
// Generic synchronous FIFO; pointers carry an extra wrap bit for full/empty.
// A push while full succeeds only when a pop happens in the same cycle.
module idli_trace_fifo_m #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [AW:0]      wr_ptr_q, wr_ptr_d;
   logic [AW:0]      rd_ptr_q, rd_ptr_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic             do_push;
   logic             do_pop;

   always_comb begin
      empty    = (wr_ptr_q == rd_ptr_q);
      full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
      do_pop   = pop && !empty;
      do_push  = push && (!full || do_pop);
      wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
      rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};
      mem_d    = mem_q;
      if (do_push) begin
         mem_d[wr_ptr_q[AW-1:0]] = wdata;
      end
      rdata    = mem_q[rd_ptr_q[AW-1:0]];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         mem_q    <= '{default: '0};
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         mem_q    <= mem_d;
      end
   end

endmodule

// File: rtl/idli_trace_m.sv
// Nibble-serial multi-channel trace capture into a per-instruction trace FIFO.
// IDLI_TRACE_TIMESTAMP_EN stores a free-running cycle count with each record.
module idli_trace_m
   import idli_pkg::*;
#(
   parameter int unsigned DATA_W   = 16,
   parameter int unsigned SLICE_W  = 4,
   parameter int unsigned CHANNELS = 2,
   parameter int unsigned DEPTH    = 8,
   parameter int unsigned CNT_W    = 8
) (
   input  logic                             i_trc_gck,
   input  logic                             i_trc_rst,
   input  logic                             i_trc_sync,
   input  logic [CHANNELS-1:0][SLICE_W-1:0] i_trc_slice,
   input  logic                             i_trc_done,
   idli_trace_m_if.master                   trc,
   output logic                             o_trc_ovf,
   output logic                             o_trc_misalign,
   output logic [CNT_W-1:0]                 o_trc_drops
);

   localparam int unsigned BEATS   = idli_trace_beats(DATA_W, SLICE_W);
   localparam int unsigned BW      = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int unsigned DWORD_W = CHANNELS * DATA_W;
   localparam int unsigned ENTRY_W = DWORD_W + $bits(idli_trace_meta_t);

   logic [BW-1:0]                   beat_q, beat_d, cur_beat;
   logic                            locked_q, locked_d;
   logic [CHANNELS-1:0][DATA_W-1:0] shift_q, shift_d;
   idli_trace_seq_t                 seq_q, seq_d;
   logic                            ovf_q, ovf_d;
   logic                            mis_q, mis_d;
   logic [CNT_W-1:0]                drops_q, drops_d;
`ifdef IDLI_TRACE_TIMESTAMP_EN
   idli_trace_time_t                time_q, time_d;
`endif

   logic                            last_beat, capture, pop, drop;
   logic                            fifo_full, fifo_empty;
   idli_trace_meta_t                wr_meta, rd_meta;
   logic [DWORD_W-1:0]              rd_data;
   logic [ENTRY_W-1:0]              wr_entry, rd_entry;

   always_comb begin
      // A sync cycle always carries slice 0, whatever the free-running count says.
      cur_beat  = i_trc_sync ? '0 : beat_q;
      last_beat = (cur_beat == BW'(BEATS - 1));
      beat_d    = last_beat ? '0 : cur_beat + 1'b1;
      locked_d  = locked_q | i_trc_sync;

      for (int unsigned ch = 0; ch < CHANNELS; ch++) begin
         shift_d[ch] = {i_trc_slice[ch], shift_q[ch][DATA_W-1:SLICE_W]};
      end

      capture  = i_trc_done && locked_d && last_beat;
      mis_d    = mis_q | (i_trc_done && locked_d && !last_beat);
      seq_d    = seq_q + 16'(capture);

      pop      = trc.o_trc_vld && trc.i_trc_rdy;
      drop     = capture && fifo_full && !pop;
      ovf_d    = ovf_q | drop;
      drops_d  = drops_q;
      if (drop && (drops_q != '1)) begin
         drops_d = drops_q + CNT_W'(1);
      end

      wr_meta       = '0;
      wr_meta.seq   = seq_q;
`ifdef IDLI_TRACE_TIMESTAMP_EN
      time_d        = time_q + 32'd1;
      wr_meta.stamp = time_q;
`endif
      // Capture takes shift_d so the record includes the slice arriving this cycle.
      wr_entry            = {wr_meta, shift_d};
      {rd_meta, rd_data}  = rd_entry;
   end

   always_ff @(posedge i_trc_gck) begin
      if (i_trc_rst) begin
         beat_q   <= '0;
         locked_q <= 1'b0;
         shift_q  <= '0;
         seq_q    <= '0;
         ovf_q    <= 1'b0;
         mis_q    <= 1'b0;
         drops_q  <= '0;
`ifdef IDLI_TRACE_TIMESTAMP_EN
         time_q   <= '0;
`endif
      end else begin
         beat_q   <= beat_d;
         locked_q <= locked_d;
         shift_q  <= shift_d;
         seq_q    <= seq_d;
         ovf_q    <= ovf_d;
         mis_q    <= mis_d;
         drops_q  <= drops_d;
`ifdef IDLI_TRACE_TIMESTAMP_EN
         time_q   <= time_d;
`endif
      end
   end

   idli_trace_fifo_m #(
      .WIDTH (ENTRY_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (i_trc_gck),
      .rst   (i_trc_rst),
      .push  (capture),
      .pop   (pop),
      .wdata (wr_entry),
      .rdata (rd_entry),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign trc.o_trc_vld  = !fifo_empty;
   assign trc.o_trc_data = rd_data;
   assign trc.o_trc_seq  = rd_meta.seq;
`ifdef IDLI_TRACE_TIMESTAMP_EN
   assign trc.o_trc_time = rd_meta.stamp;
`endif
   assign o_trc_ovf      = ovf_q;
   assign o_trc_misalign = mis_q;
   assign o_trc_drops    = drops_q;

endmodule

// File: tb/tb_idli_trace_m.sv
// Directed self-checking bench for idli_trace_m in its default configuration.
module tb_idli_trace_m;

   logic             clk = 1'b0;
   logic             rst;
   logic             sync;
   logic [1:0][3:0]  slice;
   logic             done;
   logic             ovf;
   logic             misalign;
   logic [7:0]       drops;
   int               n_cmp = 0;
   int               n_mis = 0;

   idli_trace_m_if #(.DATA_W(16), .CHANNELS(2)) trc_if ();

   idli_trace_m #(
      .DATA_W   (16),
      .SLICE_W  (4),
      .CHANNELS (2),
      .DEPTH    (8),
      .CNT_W    (8)
   ) dut (
      .i_trc_gck      (clk),
      .i_trc_rst      (rst),
      .i_trc_sync     (sync),
      .i_trc_slice    (slice),
      .i_trc_done     (done),
      .trc            (trc_if),
      .o_trc_ovf      (ovf),
      .o_trc_misalign (misalign),
      .o_trc_drops    (drops)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One 4-beat word per channel, sync on beat 0, done on done_beat (-1 for none).
   task automatic word(input logic [15:0] w0, input logic [15:0] w1,
                       input int done_beat, input logic rdy_last);
      for (int k = 0; k < 4; k++) begin
         sync  = (k == 0);
         slice = {w1[4*k +: 4], w0[4*k +: 4]};
         done  = (k == done_beat);
         trc_if.i_trc_rdy = (k == 3) ? rdy_last : 1'b0;
         tick();
      end
      sync = 1'b0;
      done = 1'b0;
      trc_if.i_trc_rdy = 1'b0;
   endtask

   task automatic pop1();
      trc_if.i_trc_rdy = 1'b1;
      tick();
      trc_if.i_trc_rdy = 1'b0;
   endtask

   initial begin
      rst = 1'b1; sync = 1'b0; slice = '0; done = 1'b0; trc_if.i_trc_rdy = 1'b0;
      tick(); tick();
      rst = 1'b0;

      chk("rst_vld",  64'(trc_if.o_trc_vld), 64'd0);
      chk("rst_data", 64'(trc_if.o_trc_data), 64'd0);
      chk("rst_seq",  64'(trc_if.o_trc_seq), 64'd0);
      chk("rst_ovf",  64'(ovf), 64'd0);
      chk("rst_mis",  64'(misalign), 64'd0);
      chk("rst_drops", 64'(drops), 64'd0);

      // Done before any sync is ignored.
      done = 1'b1; slice = 8'h5A;
      tick(); tick(); tick(); tick();
      done = 1'b0;
      chk("unlock_mis", 64'(misalign), 64'd0);
      chk("unlock_vld", 64'(trc_if.o_trc_vld), 64'd0);

      // Single capture.
      word(16'h1234, 16'hCDEF, 3, 1'b0);
      chk("single_vld",  64'(trc_if.o_trc_vld), 64'd1);
      chk("single_data", 64'(trc_if.o_trc_data), 64'hCDEF_1234);
      chk("single_seq",  64'(trc_if.o_trc_seq), 64'd0);
      tick();
      chk("single_hold", 64'(trc_if.o_trc_data), 64'hCDEF_1234);
      pop1();
      chk("single_pop_vld", 64'(trc_if.o_trc_vld), 64'd0);
      pop1();
      chk("empty_rdy_vld", 64'(trc_if.o_trc_vld), 64'd0);

      // Misaligned done, then an aligned capture.
      word(16'hAAAA, 16'hBBBB, 1, 1'b0);
      chk("mis_flag", 64'(misalign), 64'd1);
      chk("mis_vld",  64'(trc_if.o_trc_vld), 64'd0);
      word(16'h1111, 16'h2222, 3, 1'b0);
      chk("mis_next_seq",  64'(trc_if.o_trc_seq), 64'd1);
      chk("mis_next_data", 64'(trc_if.o_trc_data), 64'h2222_1111);
      pop1();

      // Overflow: 10 captures into 8 entries, seq 2..11.
      for (int i = 0; i < 10; i++) begin
         word(16'h0100 + 16'(i), 16'h0200 + 16'(i), 3, 1'b0);
      end
      chk("ovf_flag",  64'(ovf), 64'd1);
      chk("ovf_drops", 64'(drops), 64'd2);
      for (int i = 0; i < 8; i++) begin
         chk("ovf_drain_vld",  64'(trc_if.o_trc_vld), 64'd1);
         chk("ovf_drain_seq",  64'(trc_if.o_trc_seq), 64'(2 + i));
         chk("ovf_drain_data", 64'(trc_if.o_trc_data), {32'd0, 16'h0200 + 16'(i), 16'h0100 + 16'(i)});
         pop1();
      end
      chk("ovf_empty", 64'(trc_if.o_trc_vld), 64'd0);

      // Full FIFO with push and pop together: seq 12..19 fill, seq 20 pushes with a pop.
      for (int i = 0; i < 8; i++) begin
         word(16'h0300 + 16'(i), 16'h0400 + 16'(i), 3, 1'b0);
      end
      chk("full_drops_pre", 64'(drops), 64'd2);
      word(16'h0EEE, 16'h0FFF, 3, 1'b1);
      chk("full_drops_post", 64'(drops), 64'd2);
      chk("full_head_seq", 64'(trc_if.o_trc_seq), 64'd13);
      for (int i = 0; i < 8; i++) begin
         chk("full_drain_seq", 64'(trc_if.o_trc_seq), 64'(13 + i));
         if (i == 7) begin
            chk("full_tail_data", 64'(trc_if.o_trc_data), 64'h0FFF_0EEE);
         end
         pop1();
      end
      chk("full_empty", 64'(trc_if.o_trc_vld), 64'd0);

      // Reset mid-operation with 3 buffered entries.
      for (int i = 0; i < 3; i++) begin
         word(16'h0500 + 16'(i), 16'h0600 + 16'(i), 3, 1'b0);
      end
      chk("pre_rst_seq", 64'(trc_if.o_trc_seq), 64'd21);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("mid_rst_vld",   64'(trc_if.o_trc_vld), 64'd0);
      chk("mid_rst_drops", 64'(drops), 64'd0);
      chk("mid_rst_ovf",   64'(ovf), 64'd0);
      chk("mid_rst_mis",   64'(misalign), 64'd0);
      word(16'h7777, 16'h8888, 3, 1'b0);
      chk("post_rst_seq",  64'(trc_if.o_trc_seq), 64'd0);
      chk("post_rst_data", 64'(trc_if.o_trc_data), 64'h8888_7777);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
